// File: rtl/fft_out_rd_ctrl.sv
// FFT output read controller: walks a frame of N points out of 64 banks
// in natural or bit-reversed order and aligns bank select with read data.
`ifndef BANK_WIDTH
`define BANK_WIDTH 6
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fft_out_rd_ctrl #(
    parameter int N_LOG2     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bit_rev,
    input  logic                         hold,
    output logic                         rd_en,
    output logic [N_LOG2-`BANK_WIDTH-1:0] rd_bank_addr,
    output logic [`BANK_WIDTH-1:0]       sel,
    input  logic [`DATA_WIDTH-1:0]       Q_in,
    output logic [`DATA_WIDTH-1:0]       data_out,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int BW = `BANK_WIDTH;
    localparam int L  = RD_LATENCY;
    localparam logic [N_LOG2-1:0] KMAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [N_LOG2-1:0] k;
    logic [N_LOG2-1:0] addr;
    logic              rev;
    logic              issue;

    logic [L-1:0]         vld_p;
    logic [L-1:0]         last_p;
    logic [L-1:0][BW-1:0] bank_p;

    function automatic logic [N_LOG2-1:0] bit_reverse(
        input logic [N_LOG2-1:0] v
    );
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = v[N_LOG2-1-i];
        end
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = ISSUE;
            end
            ISSUE: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (k == KMAX) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (out_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign addr         = rev ? bit_reverse(k) : k;
    assign rd_en        = issue;
    assign rd_bank_addr = addr[N_LOG2-1:BW];
    assign busy         = (state != IDLE);
    assign done         = out_last;
    assign sel          = bank_p[L-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            rev   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                k   <= '0;
                rev <= bit_rev;
            end else if (issue) begin
                k <= k + 1'b1;
            end
        end
    end

    // Bank index only advances with a valid read so sel holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            last_p <= '0;
            bank_p <= '0;
        end else begin
            vld_p[0]  <= issue;
            last_p[0] <= issue && (k == KMAX);
            if (issue) bank_p[0] <= addr[BW-1:0];
            for (int i = 1; i < L; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
                if (vld_p[i-1]) bank_p[i] <= bank_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= vld_p[L-1];
            out_last  <= vld_p[L-1] && last_p[L-1];
            if (vld_p[L-1]) data_out <= Q_in;
        end
    end

endmodule

// File: tb/tb_fft_out_rd_ctrl.sv
// Bench for fft_out_rd_ctrl: two instances (N=4096/lat 1, N=128/lat 3)
// fed by bank models where bank b row r holds r*64+b.
module tb_fft_out_rd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 0, a_br = 0, a_hold = 0;
    logic        a_re, a_ov, a_ol, a_busy, a_done;
    logic [5:0]  a_addr, a_sel, a_row = '0;
    logic [31:0] a_q, a_do;

    logic        b_start = 0, b_br = 0, b_hold = 0;
    logic        b_re, b_ov, b_ol, b_busy, b_done;
    logic [0:0]  b_addr;
    logic [0:0]  b_row [3] = '{default: '0};
    logic [5:0]  b_sel;
    logic [31:0] b_q, b_do;

    fft_out_rd_ctrl #(.N_LOG2(12), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .bit_rev(a_br),
        .hold(a_hold), .rd_en(a_re), .rd_bank_addr(a_addr),
        .sel(a_sel), .Q_in(a_q), .data_out(a_do),
        .out_valid(a_ov), .out_last(a_ol), .busy(a_busy),
        .done(a_done)
    );

    fft_out_rd_ctrl #(.N_LOG2(7), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .bit_rev(b_br),
        .hold(b_hold), .rd_en(b_re), .rd_bank_addr(b_addr),
        .sel(b_sel), .Q_in(b_q), .data_out(b_do),
        .out_valid(b_ov), .out_last(b_ol), .busy(b_busy),
        .done(b_done)
    );

    always @(posedge clk) begin
        if (a_re) a_row <= a_addr;
        if (b_re) b_row[0] <= b_addr;
        b_row[1] <= b_row[0];
        b_row[2] <= b_row[1];
    end
    assign a_q = {20'b0, a_row, a_sel};
    assign b_q = {25'b0, b_row[2], b_sel};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    bit          cur = 0;
    logic        m_re, m_ov, m_ol, m_busy, m_done;
    logic [5:0]  m_sel;
    logic [31:0] m_do;
    assign m_re   = cur ? b_re   : a_re;
    assign m_ov   = cur ? b_ov   : a_ov;
    assign m_ol   = cur ? b_ol   : a_ol;
    assign m_busy = cur ? b_busy : a_busy;
    assign m_done = cur ? b_done : a_done;
    assign m_sel  = cur ? b_sel  : a_sel;
    assign m_do   = cur ? b_do   : a_do;

    bit       cap = 0;
    bit       re_q [$];
    bit       ov_q [$];
    int       dq [$];
    int       sq [$];
    int       n_iss, n_last, last_idx, viol;
    bit       got_done, busy_after, prev_done;
    int       prev_sel;

    always @(negedge clk) begin
        if (cap) begin
            re_q.push_back(m_re);
            ov_q.push_back(m_ov);
            if (m_re) n_iss++;
            if (m_ov) begin
                dq.push_back(int'(m_do));
                sq.push_back(prev_sel);
            end
            if (m_ol) begin
                n_last++;
                last_idx = dq.size() - 1;
            end
            if (m_done !== m_ol || (m_ol && !m_ov)) viol++;
            if (m_done) got_done = 1;
            if (prev_done) busy_after = m_busy;
        end
        prev_done = m_done;
        prev_sel  = int'(m_sel);
    end

    task automatic clr();
        re_q.delete(); ov_q.delete(); dq.delete(); sq.delete();
        n_iss = 0; n_last = 0; last_idx = -1; viol = 0;
        got_done = 0; busy_after = 1;
    endtask

    task automatic drive(input bit w, input bit st, input bit h);
        if (w) begin b_start = st; b_hold = h; end
        else   begin a_start = st; a_hold = h; end
    endtask

    function automatic int brev(input int v, input int nb);
        int r = 0;
        for (int i = 0; i < nb; i++)
            if (v[i]) r |= (1 << (nb - 1 - i));
        return r;
    endfunction

    typedef struct {
        bit w;
        bit br;
        int hold_at;
        int hold_len;
        int smid;
        bit pre;
        bit b2b;
        int nlog;
        int exp_beats;
        int exp_lat;
        int exp_gap;
        int exp_first;
    } vec_t;

    vec_t tbl [6];

    task automatic run_frame(input vec_t v, input string tag);
        int hcnt = 0;
        bit sdone = 0;
        bit h;
        bit st;
        int fr = -1, fo = -1, lr = -1, mm = 0, gaps = 0, bad = 0;
        cur = v.w;
        clr();
        cap = 1;
        if (v.w) b_br = v.br; else a_br = v.br;
        if (!v.pre) begin
            h = (v.hold_at == 0 && v.hold_len > 0);
            if (h) hcnt = 1;
            drive(v.w, 1'b1, h);
        end
        for (int c = 0; c < 6000 && !got_done; c++) begin
            @(posedge clk); #1;
            h = 0;
            st = 0;
            if (v.hold_len > 0 && n_iss == v.hold_at && hcnt < v.hold_len) begin
                h = 1;
                hcnt++;
            end
            if (v.smid > 0 && n_iss == v.smid && !sdone) begin
                st = 1;
                sdone = 1;
            end
            drive(v.w, st, h);
        end
        chk({tag, "_done_seen"}, int'(got_done), 1);
        @(negedge clk); #1;
        chk({tag, "_busy_after"}, int'(busy_after), 0);
        if (v.b2b) drive(v.w, 1'b1, 1'b0);
        for (int i = 0; i < re_q.size(); i++) begin
            if (re_q[i]) begin
                if (fr < 0) fr = i;
                lr = i;
            end
        end
        for (int i = 0; i < ov_q.size(); i++)
            if (ov_q[i] && fo < 0) fo = i;
        for (int i = fr; i >= 0 && i <= lr; i++) begin
            if (!re_q[i]) gaps++;
            if (i + v.exp_lat < ov_q.size() && re_q[i] != ov_q[i + v.exp_lat])
                mm++;
        end
        for (int j = 0; j < dq.size(); j++)
            if (dq[j] != (v.br ? brev(j, v.nlog) : j)) bad++;
        chk({tag, "_beats"}, dq.size(), v.exp_beats);
        chk({tag, "_rd_en_cnt"}, n_iss, v.exp_beats);
        chk({tag, "_data_bad"}, bad, 0);
        chk({tag, "_first_rd"}, fr, v.exp_first);
        chk({tag, "_latency"}, fo - fr, v.exp_lat);
        chk({tag, "_gap_mirror"}, mm, 0);
        chk({tag, "_issue_gaps"}, gaps, v.exp_gap);
        chk({tag, "_last_cnt"}, n_last, 1);
        chk({tag, "_last_idx"}, last_idx, v.exp_beats - 1);
        chk({tag, "_done_viol"}, viol, 0);
    endtask

    initial begin
        int n0;
        tbl[0] = '{0, 0,  0, 0,  0, 0, 0, 12, 4096, 2, 0, 1};
        tbl[1] = '{1, 1,  0, 0,  0, 0, 0,  7,  128, 4, 0, 1};
        tbl[2] = '{1, 0,  0, 0, 50, 0, 1,  7,  128, 4, 0, 1};
        tbl[3] = '{1, 0,  7, 2,  0, 1, 0,  7,  128, 4, 2, 0};
        tbl[4] = '{0, 0, 10, 3,  0, 0, 0, 12, 4096, 2, 3, 1};
        tbl[5] = '{0, 1,  0, 2, 20, 0, 0, 12, 4096, 2, 0, 2};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_rd_en", int'(a_re), 0);
        chk("rst_a_busy", int'(a_busy), 0);
        chk("rst_a_valid", int'(a_ov), 0);
        chk("rst_a_data", int'(a_do), 0);
        chk("rst_a_sel", int'(a_sel), 0);
        chk("rst_b_done", int'(b_done), 0);
        chk("rst_b_addr", int'(b_addr), 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            run_frame(tbl[r], $sformatf("row%0d", r));
            if (r == 1) begin
                chk("brev_beat1", dq[1], 64);
                chk("brev_beat2", dq[2], 32);
                chk("brev_beat3", dq[3], 96);
                chk("brev_beat4", dq[4], 16);
                chk("brev_beat127", dq[127], 127);
                chk("brev_sel1", sq[1], 0);
                chk("brev_sel2", sq[2], 32);
            end
            if (r == 4) begin
                chk("hold_val9", dq[9], 9);
                chk("hold_val10", dq[10], 10);
            end
            if (!tbl[r].b2b) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end

        cur = 0;
        clr();
        a_br = 0;
        drive(0, 1'b1, 1'b0);
        for (int c = 0; c < 400 && dq.size() < 100; c++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b0);
        end
        chk("pre_rst_beats", dq.size(), 100);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); #1;
        chk("mid_rst_rd_en", int'(a_re), 0);
        chk("mid_rst_addr", int'(a_addr), 0);
        chk("mid_rst_sel", int'(a_sel), 0);
        chk("mid_rst_data", int'(a_do), 0);
        chk("mid_rst_valid", int'(a_ov), 0);
        chk("mid_rst_last", int'(a_ol), 0);
        chk("mid_rst_busy", int'(a_busy), 0);
        chk("mid_rst_done", int'(a_done), 0);
        n0 = dq.size();
        repeat (30) @(negedge clk);
        chk("post_rst_beats", dq.size() - n0, 0);
        @(posedge clk); #1;
        run_frame(tbl[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
